// File: rtl/fu_wbslot_sched.sv
// fu_wbslot_sched: reserves FU6 writeback cycles at issue time so the four producers never collide on the bus.
module fu_wbslot_sched #(
    parameter int MUL_LAT = 4,
    parameter int CVT_LAT = 3,
    parameter int EXT_LAT = 1,
    parameter int TAGW    = 9,
    parameter int MAXLAT  = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            except,
    input  logic            hold,
    input  logic            mul_req,
    input  logic [TAGW-1:0] mul_tag,
    output logic            mul_gnt,
    input  logic            cvt_req,
    input  logic [TAGW-1:0] cvt_tag,
    output logic            cvt_gnt,
    input  logic            ext_req,
    input  logic [TAGW-1:0] ext_tag,
    output logic            ext_gnt,
    input  logic            alu_req,
    input  logic [TAGW-1:0] alu_tag,
    output logic            alu_gnt,
    output logic            alu_block,
    output logic            wb_valid,
    output logic [3:0]      wb_sel,
    output logic [TAGW-1:0] wb_tag,
    output logic [15:0]     blk_cnt
);
    typedef struct packed {
        logic            v;
        logic [3:0]      sel;
        logic [TAGW-1:0] tag;
    } slot_t;

    slot_t slot [0:MAXLAT];
    slot_t nxt  [0:MAXLAT];
    logic  ok;

    assign ok = !hold && !except && !rst;
    // A higher-priority request with the same latency wins regardless of its own grant, since it sees the same slot.
    assign mul_gnt = ok && mul_req && !slot[MUL_LAT].v;
    assign cvt_gnt = ok && cvt_req && !slot[CVT_LAT].v && !(mul_req && CVT_LAT == MUL_LAT);
    assign ext_gnt = ok && ext_req && !slot[EXT_LAT].v && !(mul_req && EXT_LAT == MUL_LAT)
                     && !(cvt_req && EXT_LAT == CVT_LAT);
    assign alu_gnt = ok && alu_req && !slot[1].v && !(mul_req && MUL_LAT == 1)
                     && !(cvt_req && CVT_LAT == 1) && !(ext_req && EXT_LAT == 1);

    assign alu_block = slot[1].v;
    assign wb_valid  = slot[0].v && !hold;
    assign wb_sel    = wb_valid ? slot[0].sel : 4'b0;
    assign wb_tag    = wb_valid ? slot[0].tag : '0;

    always_comb begin
        for (int k = 0; k <= MAXLAT; k++) nxt[k] = '0;
        for (int k = 0; k < MAXLAT; k++) begin
            nxt[k] = slot[k+1];
            if (alu_gnt && k == 0)         nxt[k] = {1'b1, 4'b0001, alu_tag};
            if (ext_gnt && EXT_LAT == k+1) nxt[k] = {1'b1, 4'b1000, ext_tag};
            if (cvt_gnt && CVT_LAT == k+1) nxt[k] = {1'b1, 4'b0100, cvt_tag};
            if (mul_gnt && MUL_LAT == k+1) nxt[k] = {1'b1, 4'b0010, mul_tag};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || except)
            for (int k = 0; k <= MAXLAT; k++) slot[k] <= '0;
        else if (!hold)
            for (int k = 0; k <= MAXLAT; k++) slot[k] <= nxt[k];
    end

    always_ff @(posedge clk) begin
        if (rst)
            blk_cnt <= 16'd0;
        else if (alu_req && !alu_gnt && !hold && blk_cnt != 16'hFFFF)
            blk_cnt <= blk_cnt + 16'd1;
    end
endmodule

// File: tb/tb_fu_wbslot_sched.sv
// tb_fu_wbslot_sched: directed vectors against hand-derived slot timing for fu_wbslot_sched.
module tb_fu_wbslot_sched;
    logic       clk = 0, rst, except, hold;
    logic       mul_req, cvt_req, ext_req, alu_req;
    logic [8:0] mul_tag, cvt_tag, ext_tag, alu_tag;
    logic       mul_gnt, cvt_gnt, ext_gnt, alu_gnt, alu_block, wb_valid;
    logic [3:0] wb_sel;
    logic [8:0] wb_tag;
    logic [15:0] blk_cnt;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    fu_wbslot_sched dut (
        .clk(clk), .rst(rst), .except(except), .hold(hold),
        .mul_req(mul_req), .mul_tag(mul_tag), .mul_gnt(mul_gnt),
        .cvt_req(cvt_req), .cvt_tag(cvt_tag), .cvt_gnt(cvt_gnt),
        .ext_req(ext_req), .ext_tag(ext_tag), .ext_gnt(ext_gnt),
        .alu_req(alu_req), .alu_tag(alu_tag), .alu_gnt(alu_gnt),
        .alu_block(alu_block), .wb_valid(wb_valid), .wb_sel(wb_sel),
        .wb_tag(wb_tag), .blk_cnt(blk_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {mul_req, cvt_req, ext_req, alu_req} = 4'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [3:0] gnts();
        return {mul_gnt, cvt_gnt, ext_gnt, alu_gnt};
    endfunction

    initial begin
        rst = 1; except = 0; hold = 0;
        {mul_req, cvt_req, ext_req, alu_req} = 4'b1111;
        mul_tag = 9'h15; cvt_tag = 9'h0; ext_tag = 9'h0; alu_tag = 9'h0;
        tick();
        chk("rst_gnt", gnts(), 4'b0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_blk", blk_cnt, 0);
        tick();
        chk("rst_gnt2", gnts(), 4'b0);
        chk("rst_blk2", blk_cnt, 0);
        rst = 0; idle(); mul_req = 1; settle();
        chk("lat_gnt", mul_gnt, 1);
        tick(); idle(); settle();
        for (int i = 1; i < 4; i++) begin
            chk("lat_early", wb_valid, 0);
            tick();
        end
        chk("lat_wbv", wb_valid, 1);
        chk("lat_sel", wb_sel, 4'b0010);
        chk("lat_tag", wb_tag, 9'h15);
        tick();
        chk("lat_after", wb_valid, 0);

        mul_req = 1; mul_tag = 9'h21; settle();
        chk("col_mul", mul_gnt, 1);
        tick(); idle(); cvt_req = 1; cvt_tag = 9'h33; settle();
        chk("col_cvt_blk", cvt_gnt, 0);
        tick(); settle();
        chk("col_cvt_ok", cvt_gnt, 1);
        tick(); idle(); settle();
        chk("col_alublk", alu_block, 1);
        tick();
        chk("col_wb1_sel", wb_sel, 4'b0010);
        chk("col_wb1_tag", wb_tag, 9'h21);
        tick();
        chk("col_wb2_sel", wb_sel, 4'b0100);
        chk("col_wb2_tag", wb_tag, 9'h33);
        tick();
        chk("col_after", wb_valid, 0);

        ext_req = 1; ext_tag = 9'h44; alu_req = 1; alu_tag = 9'h55; settle();
        chk("same_gnt", gnts(), 4'b0010);
        chk("same_blk0", blk_cnt, 0);
        tick(); idle(); settle();
        chk("same_blk1", blk_cnt, 1);
        chk("same_sel", wb_sel, 4'b1000);
        chk("same_tag", wb_tag, 9'h44);
        tick();

        mul_req = 1; mul_tag = 9'h66; settle();
        chk("hold_mul", mul_gnt, 1);
        tick(); idle(); tick();
        hold = 1; mul_req = 1; alu_req = 1; settle();
        for (int i = 0; i < 3; i++) begin
            chk("hold_gnt", gnts(), 4'b0);
            chk("hold_wbv", wb_valid, 0);
            tick();
        end
        hold = 0; idle(); settle();
        chk("hold_blk", blk_cnt, 1);
        chk("hold_t5", wb_valid, 0);
        tick();
        chk("hold_t6", wb_valid, 0);
        tick();
        chk("hold_t7", wb_valid, 1);
        chk("hold_tag", wb_tag, 9'h66);
        tick();

        mul_req = 1; mul_tag = 9'h77; cvt_req = 1; cvt_tag = 9'h78; settle();
        chk("fl_gnt", gnts(), 4'b1100);
        tick(); idle(); except = 1; alu_req = 1; settle();
        chk("fl_exc_gnt", gnts(), 4'b0);
        tick(); except = 0; alu_tag = 9'h99; settle();
        chk("fl_alublk", alu_block, 0);
        chk("fl_alu_gnt", alu_gnt, 1);
        chk("fl_t2_wbv", wb_valid, 0);
        tick(); idle(); settle();
        chk("fl_t3_sel", wb_sel, 4'b0001);
        chk("fl_t3_tag", wb_tag, 9'h99);
        tick();
        chk("fl_t4_wbv", wb_valid, 0);
        chk("fl_blk", blk_cnt, 2);

        ext_req = 1; alu_req = 1;
        repeat (65540) tick();
        chk("sat_blk", blk_cnt, 16'hFFFF);
        idle(); mul_req = 1; mul_tag = 9'h1AB; settle();
        chk("rr_gnt", mul_gnt, 1);
        tick(); idle(); rst = 1; tick(); rst = 0; settle();
        chk("rr_blk", blk_cnt, 0);
        for (int i = 0; i < 4; i++) begin
            chk("rr_wbv", wb_valid, 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
